// File: rtl/ir_transmitter_peripheral.sv
// ir_transmitter_peripheral: bus-written 4-bit drive command, re-sent each packet period as a carrier-modulated IR packet.
// Define IR_STATUS_READ_EN to enable the registered {busy, COMMAND} status read at BASE_ADDR+1.
module ir_transmitter_peripheral #(
   parameter logic [7:0] BASE_ADDR = 8'h90,
   parameter int CLK_FREQ          = 100_000_000,
   parameter int CARRIER_FREQ      = 36_000,
   parameter int START_BURST       = 88,
   parameter int SELECT_BURST      = 22,
   parameter int ASSERT_BURST      = 44,
   parameter int DEASSERT_BURST    = 22,
   parameter int GAP_LEN           = 40,
   parameter int PACKET_PERIOD_CYC = 10_000_000
) (
   input  logic       CLK,
   input  logic       RESET,
   inout  wire  [7:0] BUS_DATA,
   input  logic [7:0] BUS_ADDR,
   input  logic       BUS_WE,
   output logic       IR_LED
);
   localparam int HALF = CLK_FREQ / (2 * CARRIER_FREQ);
   localparam int CW = $clog2(HALF + 1);
   localparam int PW = $clog2(PACKET_PERIOD_CYC + 1);
   typedef enum logic [2:0] {IDLE, START, SELECT, RIGHT, LEFT, BACK, FWD, GAP} state_t;
   state_t state, state_n;
   logic [2:0] fld, fld_n;
   logic [CW-1:0] car_cnt;
   logic [PW-1:0] per_cnt;
   logic [15:0] len_cnt, len;
   logic [3:0] command, snap;
   logic carrier, armed, wr, tick, car_end, car_rise, last, burst, busy, unused_hi;
   assign wr = BUS_WE && BUS_ADDR == BASE_ADDR;
   assign tick = per_cnt == PW'(PACKET_PERIOD_CYC - 1);
   assign car_end = car_cnt == CW'(HALF - 1);
   assign car_rise = car_end && !carrier;
   assign busy = state != IDLE;
   assign unused_hi = ^BUS_DATA[7:4];
   assign len = state == START  ? 16'(START_BURST) :
                state == SELECT ? 16'(SELECT_BURST) :
                state == GAP    ? 16'(GAP_LEN) :
                snap[2'(state - RIGHT)] ? 16'(ASSERT_BURST) : 16'(DEASSERT_BURST);
   assign last = car_rise && len_cnt == len - 16'd1;
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
         fld <= '0;
      end else begin
         state <= state_n;
         fld <= fld_n;
      end
   end
   // fld remembers which field follows the current GAP; IDLE there ends the packet
   always_comb begin
      state_n = state;
      fld_n = fld;
      if (state == IDLE) state_n = armed && car_rise ? START : IDLE;
      else if (last) begin
         state_n = state == GAP ? state_t'(fld) : GAP;
         fld_n = state == GAP ? fld : state == FWD ? 3'(IDLE) : 3'(state + 3'd1);
      end
   end
   always_comb burst = state != IDLE && state != GAP;
   // a tick only arms the packet; it starts on the next carrier rise so the first half-period is whole
   always_ff @(posedge CLK) begin
      if (RESET) begin
         car_cnt <= '0;
         carrier <= 1'b0;
         per_cnt <= '0;
         len_cnt <= '0;
         command <= '0;
         snap <= '0;
         armed <= 1'b0;
         IR_LED <= 1'b0;
      end else begin
         car_cnt <= car_end ? '0 : car_cnt + CW'(1);
         carrier <= carrier ^ car_end;
         per_cnt <= tick ? '0 : per_cnt + PW'(1);
         len_cnt <= state == IDLE || last ? '0 : car_rise ? len_cnt + 16'd1 : len_cnt;
         if (wr) command <= BUS_DATA[3:0];
         if (tick && !busy) snap <= wr ? BUS_DATA[3:0] : command;
         armed <= tick && !busy ? 1'b1 : armed && !car_rise;
         IR_LED <= burst && carrier;
      end
   end
`ifdef IR_STATUS_READ_EN
   logic rd_en;
   logic [7:0] rd_data;
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rd_en <= 1'b0;
         rd_data <= '0;
      end else begin
         rd_en <= !BUS_WE && BUS_ADDR == BASE_ADDR + 8'd1;
         rd_data <= {3'b0, busy, command};
      end
   end
   assign BUS_DATA = rd_en ? rd_data : 8'hzz;
`else
   assign BUS_DATA = 8'hzz;
`endif
endmodule
